mem_write_buffer: RTL and testbench
===================================

// Module: mem_write_buffer
// PURPOSE
//  Data-memory front end consumed by the MEM stage: takes memread/memwrite, alu_result (address) and
//  rdata2out (store data), returns read_data to MEM/WB. Stores are posted into a FIFO write buffer and
//  drained to an external single-port memory bus in the background. Asserts stall to freeze the pipeline
//  on buffer-full or on load miss. Sits between the MEM stage and the data-memory bus.
// PARAMETERS
//  DEPTH    4   write-buffer entries; power of 2, >= 2
//  AW       32  address width; word-aligned, compare uses addr[AW-1:2]
//  DW       32  data width
// PORTS
//  clock      in   1   single clock, rising edge
//  reset      in   1   synchronous, active-high
//  memread    in   1   load request from MEM stage, held while stall=1
//  memwrite   in   1   store request from MEM stage, held while stall=1
//  addr       in   AW  load/store address (alu_result)
//  wdata      in   DW  store data (rdata2out)
//  read_data  out  DW  load result, valid in the cycle memread=1 && stall=0
//  stall      out  1   freeze IF..MEM; combinational
//  bus_req    out  1   registered; held until bus_ack
//  bus_we     out  1   1=write, 0=read; stable while bus_req
//  bus_addr   out  AW  stable while bus_req
//  bus_wdata  out  DW  stable while bus_req
//  bus_ack    in   1   one-cycle pulse; earliest in the first cycle bus_req=1
//  bus_rdata  in   DW  valid with bus_ack when bus_we=0
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, read_data=0, stall=0.
//  FSM: IDLE -> DRAIN when FIFO non-empty and no read is pending; DRAIN: bus_req=1, bus_we=1, head entry
//   on bus; on bus_ack pop head -> IDLE. IDLE -> RD when a load misses; RD: bus_req=1, bus_we=0; on bus_ack
//   capture bus_rdata into rdata_q -> RDONE. RDONE: stall=0, read_data=rdata_q for one cycle -> IDLE.
//  A pending load has priority over starting a new drain; an in-flight drain is never aborted.
//  Store: memwrite && !full -> push {addr,wdata} at the clock edge, stall=0 (zero-latency post).
//   memwrite && full -> stall=1; a pop in the same cycle does not release the stall (push next cycle).
//  Load hit/miss: see CONFIGURATION. Load latency on miss: >= 3 cycles (RD issue, ack, RDONE).
//  memread && memwrite both set: illegal; load served, store ignored; simulation assertion fires.
//  FIFO pointers: log2(DEPTH)+1 bits, wrap modulo DEPTH; full = ptr MSBs differ and low bits equal.
//  Push and pop in the same cycle with FIFO non-full: both occur, count unchanged.
//  Reset mid-transaction: FSM -> IDLE, FIFO flushed, bus_req drops next edge; a late bus_ack is ignored.
// CONFIGURATION
//  WBUF_FORWARD_EN defined: load address compared against all valid entries; the youngest match
//   returns its data combinationally the same cycle (stall=0, no bus read). A miss goes to RD immediately,
//   bypassing queued stores (no RAW hazard since no match).
//  Undefined: no comparator; every load stalls until the FIFO is empty and the FSM is IDLE, then enters RD.
// STRUCTURE
//  Package mem_wbuf_pkg: state enum {IDLE,DRAIN,RD,RDONE}; wbuf_entry_t struct {addr,data};
//   localparam PTR_W = $clog2(DEPTH).
//  Sub-module wbuf_fifo: DEPTH-entry sync FIFO with push/pop/full/empty/head, plus a flat view of all
//   entries and the valid mask (used by the forward search).
//  Top module: FSM, bus regs, stall/read_data muxing, forward priority search.
// TESTING
//  1 Reset with bus_ack=1: bus_req=0, stall=0, read_data=0 throughout reset and the first cycle after.
//  2 Five stores 0x10..0x20 data 1..5, bus_ack withheld: first 4 posted with stall=0, 5th stall=1 until
//    the first ack, then posted; bus sees writes in order 0x10,0x14,0x18,0x1C,0x20.
//  3 FWD_EN: store 0x40<-0xAA, then 0x40<-0xBB, then load 0x40 -> read_data=0xBB same cycle, no bus read.
//  4 No FWD_EN: same sequence -> stall until both writes acked, bus read 0x40, read_data=bus_rdata in RDONE.
//  5 Load miss 0x80 while DRAIN in flight: the drain completes first, then bus read 0x80; stall=1 until RDONE.
//  6 Assert reset during RD with bus_req=1: FSM IDLE, FIFO empty next cycle; an ack arriving afterwards
//    has no effect.

Source files
------------

// File: rtl/mem_wbuf_pkg.sv
// Shared types for the MEM-stage write buffer: FSM states, FIFO entry payload, pointer width.
package mem_wbuf_pkg;

    localparam int unsigned WBUF_DEPTH = 4;
    localparam int unsigned WBUF_AW    = 32;
    localparam int unsigned WBUF_DW    = 32;
    localparam int unsigned PTR_W      = $clog2(WBUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RD    = 2'd2,
        RDONE = 2'd3
    } wbuf_state_e;

    typedef struct packed {
        logic [WBUF_AW-1:0] addr;
        logic [WBUF_DW-1:0] data;
    } wbuf_entry_t;

    // Word-granular address compare; byte offset bits are ignored.
    function automatic logic word_match(input logic [WBUF_AW-1:0] a, input logic [WBUF_AW-1:0] b);
        return a[WBUF_AW-1:2] == b[WBUF_AW-1:2];
    endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// DEPTH-entry synchronous FIFO of posted stores; also exposes all entries in age order
// (index 0 = oldest) with a valid mask so the top can search for the youngest match.
module wbuf_fifo
    import mem_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  wbuf_entry_t             push_entry,
    input  logic                    pop,
    output logic                    full,
    output logic                    empty,
    output wbuf_entry_t             head,
    output wbuf_entry_t [DEPTH-1:0] entries,
    output logic [DEPTH-1:0]        valid
);

    localparam int unsigned PW = $clog2(DEPTH);

    wbuf_entry_t   mem [DEPTH];
    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW:0]   count;

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PW-1:0]] <= push_entry;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[PW-1:0]];

    // Rotate storage so entries[k] is the k-th oldest occupant.
    always_comb begin
        entries = '0;
        valid   = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            entries[k] = mem[PW'(rd_ptr[PW-1:0] + PW'(k))];
            valid[k]   = ((PW+1)'(k) < count);
        end
    end

endmodule

// File: rtl/mem_write_buffer.sv
// MEM-stage data-memory front end: posts stores into a write buffer drained in the background,
// serves loads via bus reads. Define WBUF_FORWARD_EN to forward loads from buffered stores.
module mem_write_buffer
    import mem_wbuf_pkg::*;
#(
    parameter int unsigned DEPTH = WBUF_DEPTH,
    parameter int unsigned AW    = WBUF_AW,
    parameter int unsigned DW    = WBUF_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] read_data,
    output logic          stall,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ack,
    input  logic [DW-1:0] bus_rdata
);

    wbuf_state_e             state;
    wbuf_state_e             state_d;
    logic                    bus_req_d;
    logic                    bus_we_d;
    logic [AW-1:0]           bus_addr_d;
    logic [DW-1:0]           bus_wdata_d;
    logic [DW-1:0]           rdata_q;
    logic [DW-1:0]           rdata_d;

    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    wbuf_entry_t             head;
    wbuf_entry_t             push_entry;
    wbuf_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]        valid;

    logic                    fwd_hit;
    logic [DW-1:0]           fwd_data;
    logic                    rd_start;

    // A simultaneous load wins; the store is dropped.
    assign push       = memwrite && !memread && !full;
    assign push_entry = '{addr: WBUF_AW'(addr), data: WBUF_DW'(wdata)};

    wbuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .entries    (entries),
        .valid      (valid)
    );

`ifdef WBUF_FORWARD_EN
    // Later (younger) matches override earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (valid[k] && word_match(entries[k].addr, WBUF_AW'(addr))) begin
                fwd_hit  = 1'b1;
                fwd_data = DW'(entries[k].data);
            end
        end
    end

    // A miss cannot alias any queued store, so it may bypass them.
    assign rd_start = memread && !fwd_hit;
`else
    logic unused_fwd_view;

    assign unused_fwd_view = ^{entries, valid};
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
    assign rd_start        = memread && empty;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            bus_req   <= bus_req_d;
            bus_we    <= bus_we_d;
            bus_addr  <= bus_addr_d;
            bus_wdata <= bus_wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    // Next-state and bus launch; bus fields are loaded on entry to DRAIN/RD and held until ack.
    always_comb begin
        state_d     = state;
        bus_req_d   = bus_req;
        bus_we_d    = bus_we;
        bus_addr_d  = bus_addr;
        bus_wdata_d = bus_wdata;
        rdata_d     = rdata_q;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if (rd_start) begin
                    state_d    = RD;
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = addr;
                end else if (!empty) begin
                    state_d     = DRAIN;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = AW'(head.addr);
                    bus_wdata_d = DW'(head.data);
                end
            end
            DRAIN: begin
                if (bus_ack) begin
                    pop       = 1'b1;
                    bus_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            RD: begin
                if (bus_ack) begin
                    rdata_d   = bus_rdata;
                    bus_req_d = 1'b0;
                    state_d   = RDONE;
                end
            end
            RDONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline freeze and load return; full is registered, so a same-cycle pop cannot unstall a store.
    always_comb begin
        stall     = 1'b0;
        read_data = '0;
        if (!reset) begin
            if (state == RDONE) begin
                read_data = rdata_q;
            end else if (memread) begin
                if (fwd_hit) begin
                    read_data = fwd_data;
                end else begin
                    stall = 1'b1;
                end
            end else if (memwrite) begin
                stall = full;
            end
        end
    end

    a_no_load_store_overlap: assert property (@(posedge clock) disable iff (reset) !(memread && memwrite));

endmodule

// File: tb/tb_mem_write_buffer.sv
// Directed self-checking bench for mem_write_buffer (both WBUF_FORWARD_EN builds).
module tb_mem_write_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;

    mem_write_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .addr      (addr),
        .wdata     (wdata),
        .read_data (read_data),
        .stall     (stall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clock = ~clock;

    // Waits (bounded) for bus_req at a negedge, records the request, then acks it for one cycle.
    task automatic serve_bus(input logic [31:0] rdata, output logic we, output logic [31:0] a,
                             output logic [31:0] d, output bit ok);
        ok = 1'b0;
        we = 1'b0;
        a  = '0;
        d  = '0;
        for (int n = 0; n < 20; n++) begin
            if (bus_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) begin
            we        = bus_we;
            a         = bus_addr;
            d         = bus_wdata;
            bus_ack   = 1'b1;
            bus_rdata = rdata;
            @(negedge clock);
            bus_ack   = 1'b0;
            bus_rdata = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_bus_req[%0d]: got %b want 0", i, bus_req); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall[%0d]: got %b want 0", i, stall); end
            checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL rst_read_data[%0d]: got %h want 0", i, read_data); end
        end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL post_rst_bus_req: got %b want 0", bus_req); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL post_rst_stall: got %b want 0", stall); end
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL post_rst_read_data: got %h want 0", read_data); end
        checks++; if (bus_addr !== 32'h0 || bus_we !== 1'b0 || bus_wdata !== 32'h0) begin errors++; $display("FAIL post_rst_bus_regs: got we=%b a=%h d=%h want 0", bus_we, bus_addr, bus_wdata); end
        bus_ack = 1'b0; bus_rdata = '0;
        @(negedge clock);
    endtask

    task automatic test_store_full();
        logic [31:0] exp_a [4] = '{32'h14, 32'h18, 32'h1C, 32'h20};
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        bit          ok;
        for (int i = 0; i < 4; i++) begin
            memwrite = 1'b1; addr = 32'h10 + 32'(4 * i); wdata = 32'(i + 1);
            #1;
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store%0d_stall: got %b want 0", i, stall); end
            @(negedge clock);
        end
        addr = 32'h20; wdata = 32'h5;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall[%0d]: got %b want 1", i, stall); end
            checks++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h10 || bus_wdata !== 32'h1) begin
                errors++; $display("FAIL first_drain: got req=%b we=%b a=%h d=%h want 1 1 10 1", bus_req, bus_we, bus_addr, bus_wdata); end
            @(negedge clock);
        end
        bus_ack = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ack_cycle_stall: got %b want 1", stall); end
        @(negedge clock);
        bus_ack = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL after_pop_stall: got %b want 0", stall); end
        @(negedge clock);
        memwrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serve_bus(32'h0, we, a, d, ok);
            checks++; if (ok !== 1'b1 || we !== 1'b1 || a !== exp_a[i] || d !== 32'(i + 2)) begin
                errors++; $display("FAIL drain%0d: got ok=%b we=%b a=%h d=%h want 1 1 %h %h", i, ok, we, a, d, exp_a[i], 32'(i + 2)); end
        end
        repeat (3) @(negedge clock);
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL drained_idle: got %b want 0", bus_req); end
    endtask

`ifdef WBUF_FORWARD_EN
    task automatic test_forward();
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        bit          ok;
        memwrite = 1'b1; addr = 32'h40; wdata = 32'hAA;
        @(negedge clock);
        wdata = 32'hBB;
        @(negedge clock);
        memwrite = 1'b0; memread = 1'b1; addr = 32'h40;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b want 0", stall); end
        checks++; if (read_data !== 32'hBB) begin errors++; $display("FAIL fwd_data: got %h want bb", read_data); end
        @(negedge clock);
        memread = 1'b0;
        for (int i = 0; i < 2; i++) begin
            serve_bus(32'h0, we, a, d, ok);
            checks++; if (ok !== 1'b1 || we !== 1'b1 || a !== 32'h40) begin
                errors++; $display("FAIL fwd_drain%0d: got ok=%b we=%b a=%h want 1 1 40", i, ok, we, a); end
        end
        repeat (3) @(negedge clock);
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL fwd_no_read: got %b want 0", bus_req); end
    endtask
`else
    task automatic test_no_forward();
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        bit          ok;
        memwrite = 1'b1; addr = 32'h40; wdata = 32'hAA;
        @(negedge clock);
        wdata = 32'hBB;
        @(negedge clock);
        memwrite = 1'b0; memread = 1'b1; addr = 32'h40;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nofwd_stall: got %b want 1", stall); end
        serve_bus(32'h0, we, a, d, ok);
        checks++; if (ok !== 1'b1 || we !== 1'b1 || d !== 32'hAA) begin errors++; $display("FAIL nofwd_w0: got ok=%b we=%b d=%h want 1 1 aa", ok, we, d); end
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nofwd_mid_stall: got %b want 1", stall); end
        serve_bus(32'h0, we, a, d, ok);
        checks++; if (ok !== 1'b1 || we !== 1'b1 || d !== 32'hBB) begin errors++; $display("FAIL nofwd_w1: got ok=%b we=%b d=%h want 1 1 bb", ok, we, d); end
        serve_bus(32'h1234_5678, we, a, d, ok);
        checks++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h40) begin errors++; $display("FAIL nofwd_rd: got ok=%b we=%b a=%h want 1 0 40", ok, we, a); end
        #1;
        checks++; if (stall !== 1'b0 || read_data !== 32'h1234_5678) begin
            errors++; $display("FAIL nofwd_rdone: got stall=%b data=%h want 0 12345678", stall, read_data); end
        @(negedge clock);
        memread = 1'b0;
        #1;
        checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL nofwd_after: got %h want 0", read_data); end
        @(negedge clock);
    endtask
`endif

    task automatic test_load_during_drain();
        logic        we;
        logic [31:0] a;
        logic [31:0] d;
        bit          ok;
        memwrite = 1'b1; addr = 32'h60; wdata = 32'h77;
        @(negedge clock);
        memwrite = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (bus_req === 1'b1) begin ok = 1'b1; break; end
            @(negedge clock);
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ld_drain_start: got %b want 1", ok); end
        memread = 1'b1; addr = 32'h80;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_miss_stall: got %b want 1", stall); end
        serve_bus(32'h0, we, a, d, ok);
        checks++; if (ok !== 1'b1 || we !== 1'b1 || a !== 32'h60 || d !== 32'h77) begin
            errors++; $display("FAIL ld_drain_first: got ok=%b we=%b a=%h d=%h want 1 1 60 77", ok, we, a, d); end
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_wait_stall: got %b want 1", stall); end
        serve_bus(32'hCAFE_F00D, we, a, d, ok);
        checks++; if (ok !== 1'b1 || we !== 1'b0 || a !== 32'h80) begin
            errors++; $display("FAIL ld_read: got ok=%b we=%b a=%h want 1 0 80", ok, we, a); end
        #1;
        checks++; if (stall !== 1'b0 || read_data !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL ld_rdone: got stall=%b data=%h want 0 cafef00d", stall, read_data); end
        @(negedge clock);
        memread = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset_mid_read();
        memread = 1'b1; addr = 32'h90;
        @(negedge clock);
        checks++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h90) begin
            errors++; $display("FAIL rd_issue: got req=%b we=%b a=%h want 1 0 90", bus_req, bus_we, bus_addr); end
        reset = 1'b1; memread = 1'b0;
        @(negedge clock);
        reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rd_reset_req: got %b want 0", bus_req); end
        @(negedge clock);
        bus_ack = 1'b0; bus_rdata = '0;
        #1;
        checks++; if (bus_req !== 1'b0 || read_data !== 32'h0 || stall !== 1'b0) begin
            errors++; $display("FAIL late_ack: got req=%b data=%h stall=%b want 0 0 0", bus_req, read_data, stall); end
        repeat (2) @(negedge clock);
        checks++; if (bus_req !== 1'b0 || read_data !== 32'h0) begin
            errors++; $display("FAIL late_ack_idle: got req=%b data=%h want 0 0", bus_req, read_data); end
    endtask

    task automatic test_reset_flush();
        memwrite = 1'b1; addr = 32'hB0; wdata = 32'h1;
        @(negedge clock);
        addr = 32'hB4; wdata = 32'h2;
        @(negedge clock);
        memwrite = 1'b0;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL flush_drain_req: got %b want 1", bus_req); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; bus_ack = 1'b1;
        @(negedge clock);
        bus_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL flush_idle[%0d]: got %b want 0", i, bus_req); end
            @(negedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_store_full();
`ifdef WBUF_FORWARD_EN
        test_forward();
`else
        test_no_forward();
`endif
        test_load_during_drain();
        test_reset_mid_read();
        test_reset_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
